debug_monitor: RTL
==================

# debug_monitor

Host-side controller for the CPU core's debug port, sitting between board buttons and a UART TX pin on one side and the core's `debug_*` inputs and `debug_data` output on the other. It debounces a step button into clean `debug_step` pulses and scans all 32 registers plus the PC through `debug_addr`. Each sampled `debug_data` word is serialized as ASCII hex over an 8N1 UART, so a single-stepped program can be observed from a terminal.

## Interface
- `CLK_DIV`, 868, clk cycles per UART bit; legal values are 2 and up.
- `DEB_CYCLES`, 100000, consecutive stable synchronized samples required to accept a new button level.
- `STEP_HIGH`, 4, clk cycles that `debug_step` is held high per step; the same count is then held low.
- `SETTLE`, 2, clk cycles between a `debug_addr` change and sampling `debug_data`.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `step_btn` in 1: raw asynchronous step button, active-high.
- `dump_req` in 1: single-cycle synchronous pulse requesting a register dump.
- `debug_data` in 32: read data from the core.
- `debug_en` out 1: debug mode enable to the core.
- `debug_step` out 1: step clock to the core; the core advances on its rising edge.
- `debug_addr` out 7: bit 6 set selects PC; otherwise bits 4:0 select a register.
- `tx` out 1: UART serial output, idle high.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
**Reset values:** `debug_en`=0, `debug_step`=0, `debug_addr`=0, `tx`=1, `busy`=0, pending flags cleared, FSM in IDLE.

**Debug enable and button handling**
- `debug_en` goes to 1 on the first clk edge after `rst` deasserts and stays at 1.
- `step_btn` passes through a 2-FF synchronizer and then the debouncer. A debounced 0→1 transition sets `step_pend`. A release creates no event.

**Dump requests**
- `dump_req`=1 sets `dump_pend`.
- Both pending flags are 1 deep, so extra requests while a flag is set are dropped.

**FSM states**
- IDLE:
  - If `step_pend` is set, go to STEP_HI.
  - Else if `dump_pend` is set, go to ADDR.
  - If both are set, the step is serviced first.
- STEP_HI: `debug_step`=1 for `STEP_HIGH` cycles, then go to STEP_LO.
- STEP_LO: `debug_step`=0 for `STEP_HIGH` cycles.
  - Clear `step_pend`.
  - With the dump feature (see Configuration), set `dump_pend`.
  - Return to IDLE.
- ADDR: load `debug_addr` with the current index: 0..31 is 7'h00..7'h1F; index 32 is 7'h40. Go to SETTLE.
- SETTLE: wait `SETTLE` cycles, capture `debug_data` into `word_r`, then go to SEND.
- SEND: transmit the characters of `word_r` one at a time, waiting for the UART to go idle before each one.
  - Word characters are 8 hex digits, MSB nibble first, using uppercase ASCII '0'-'9' and 'A'-'F'.
  - Terminator for indices 0..31: 0x20 (space).
  - Terminator for index 32: 0x0D, 0x0A.
  - Afterwards go to NEXT.
- NEXT:
  - If index is 32, clear `dump_pend`, set index to 0, and return to IDLE.
  - Otherwise increment index and go to ADDR.

**Dump length:** a full dump is 298 characters.

**UART framing:** 8N1, LSB first.
- Frame order: start bit 0, 8 data bits, stop bit 1.
- Each bit lasts exactly `CLK_DIV` clk cycles.
- The bit counter and baud counter live in a TX sub-block with handshake `load`/`ready`. `ready` is high in the cycle after the stop bit completes.

**Boundary conditions**
- A step request during a dump stays pending and is serviced after the dump finishes. That step then triggers its own dump.
- A `dump_req` during a dump with `dump_pend` already set is dropped.
- Index wraps 32→0 only through NEXT.
- Asserting `rst` mid-frame forces `tx`=1 immediately. The frame is truncated, with no stop-bit completion.
- `debug_step` is never high in any state other than STEP_HI.

## Timing
- Debounced button edge → `step_pend` set on the next cycle.
- From IDLE with `step_pend` set, `debug_step` rises 1 cycle later.
- Total step pulse lasts 2×`STEP_HIGH` cycles.
- The first start bit on `tx` appears at `SETTLE`+2 cycles after ADDR is entered.
- Consecutive characters are separated by at most 1 idle cycle.
- `busy` rises in the cycle the FSM leaves IDLE and falls when it re-enters IDLE.

## Configuration
- `DEBUG_AUTODUMP_EN` defined: every completed step sets `dump_pend`, so a full dump follows each step.
- `DEBUG_AUTODUMP_EN` undefined: steps never dump. Dumps occur only on `dump_req`.

## Test plan
Bench parameters: `CLK_DIV`=4, `DEB_CYCLES`=3, `STEP_HIGH`=2, `SETTLE`=1. The bench model returns `debug_data`=0xA5000000|addr, and 0x00400010 for PC.
- Reset check: assert `rst` mid-operation → `tx`=1, `debug_step`=0, `debug_addr`=0, `busy`=0 in the same cycle. `debug_en`=1 one cycle after release.
- Debounce: `step_btn` glitches high for 2 cycles → no `debug_step` pulse. Held high for 10 cycles → exactly one 2-high/2-low pulse.
- Dump content: `dump_req` pulse → decoded UART stream starts "A5000000 A5000001 ", ends "A500001F 00400010\r\n", 298 characters total. `debug_addr` sequence is 0..31 then 0x40.
- Frame timing: first character '0'/'A' → start bit low for exactly 4 cycles, data LSB first, stop bit high for 4 cycles.
- Overlap: `step_btn` pressed during a dump → no `debug_step` until `busy` falls, then one pulse. A second `dump_req` mid-dump is dropped.
- Macro: with `DEBUG_AUTODUMP_EN` → a step yields 298 characters. Without it → a step yields 0 characters.

Source files
------------

// File: rtl/debug_monitor.sv
// debug_monitor: host-side controller for the core's debug port.
//   - 2-FF synchronizer plus debouncer on the step button; each accepted press
//     produces one STEP_HIGH-high / STEP_HIGH-low pulse on debug_step.
//   - On request, scans registers 0..31 and then the PC through debug_addr.
//     Each sampled word goes out over an 8N1 UART as 8 uppercase hex digits,
//     followed by a space, or by CR LF after the PC.
// Optional feature: define DEBUG_AUTODUMP_EN to run a full dump after every step.

// UART transmitter, 8N1, LSB first, CLK_DIV clk cycles per bit.
// ready is low from the load cycle until the stop bit has fully elapsed.
module debug_monitor_uart_tx #(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;   // 0 = start bit, 1..8 = data bits, 9 = stop bit
  logic [8:0]    shreg;     // remaining data bits with the stop bit on top
  logic          active;

  assign ready = ~active;

  // Frame sequencer: start bit on load, then shift out one bit per CLK_DIV cycles.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= 1'b1;
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
    end else if (!active) begin
      if (load) begin
        tx       <= 1'b0;
        active   <= 1'b1;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        shreg    <= {1'b1, data};
      end
    end else if (baud_cnt == BW'(CLK_DIV - 1)) begin
      baud_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        active <= 1'b0;               // stop bit done, line already high
      end else begin
        tx      <= shreg[0];
        shreg   <= {1'b1, shreg[8:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else begin
      baud_cnt <= baud_cnt + BW'(1);
    end
  end

endmodule

module debug_monitor #(
  parameter int CLK_DIV    = 868,
  parameter int DEB_CYCLES = 100000,
  parameter int STEP_HIGH  = 4,
  parameter int SETTLE     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_btn,
  input  logic        dump_req,
  input  logic [31:0] debug_data,
  output logic        debug_en,
  output logic        debug_step,
  output logic [6:0]  debug_addr,
  output logic        tx,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP_HI,
    S_STEP_LO,
    S_ADDR,
    S_SETTLE,
    S_SEND,
    S_NEXT
  } state_t;

  localparam int DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int WAIT_MAX = (STEP_HIGH > SETTLE) ? STEP_HIGH : SETTLE;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [5:0] PC_INDEX = 6'd32;

  // Button path
  logic             btn_meta;
  logic             btn_sync;
  logic             deb_level;
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_accept;
  logic             step_rise;

  // Sequencer
  state_t            state;
  logic              step_pend;
  logic              dump_pend;
  logic [5:0]        idx;        // 0..31 registers, 32 = PC
  logic [3:0]        ch;         // character position within the current word
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       word_r;
  logic              idx_is_pc;
  logic              last_char;

  // UART handshake and character selection
  logic       tx_ready;
  logic       tx_load;
  logic [7:0] tx_char;
  logic [3:0] nibble;
  logic [4:0] nib_lsb;

  assign idx_is_pc = (idx == PC_INDEX);
  assign last_char = idx_is_pc ? (ch == 4'd9) : (ch == 4'd8);
  assign tx_load   = (state == S_SEND) && tx_ready;

  // Debug mode is entered on the first edge out of reset and never left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) debug_en <= 1'b0;
    else     debug_en <= 1'b1;
  end

  // Two-flop synchronizer for the raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= step_btn;
      btn_sync <= btn_meta;
    end
  end

  // A new level is accepted after DEB_CYCLES consecutive samples that differ
  // from the current one; any agreeing sample restarts the count.
  assign deb_accept = (btn_sync != deb_level) && (int'(deb_cnt) >= DEB_CYCLES - 1);
  assign step_rise  = deb_accept && btn_sync;

  // Debouncer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else if (btn_sync == deb_level) begin
      deb_cnt <= '0;
    end else if (deb_accept) begin
      deb_level <= btn_sync;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // Character to send: 8 hex digits MSB first, then the word terminator.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    nib_lsb = 5'd28 - {ch[2:0], 2'b00};
    nibble  = word_r[nib_lsb +: 4];
    tx_char = 8'h20;
    if (ch < 4'd8) begin
      tx_char = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                 : (8'h37 + {4'h0, nibble});
    end else if (ch == 4'd8) begin
      tx_char = idx_is_pc ? 8'h0D : 8'h20;
    end else begin
      tx_char = 8'h0A;
    end
  end

  // Main sequencer: step pulses, address scan, word capture and character
  // issue. Pending-flag sets are placed after the case so a request arriving
  // in the same cycle as a clear is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      debug_step <= 1'b0;
      debug_addr <= '0;
      busy       <= 1'b0;
      step_pend  <= 1'b0;
      dump_pend  <= 1'b0;
      idx        <= '0;
      ch         <= '0;
      wait_cnt   <= '0;
      word_r     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Steps take priority so a dump always reflects the latest state.
          if (step_pend) begin
            state      <= S_STEP_HI;
            debug_step <= 1'b1;
            busy       <= 1'b1;
            wait_cnt   <= '0;
          end else if (dump_pend) begin
            state <= S_ADDR;
            busy  <= 1'b1;
          end
        end

        S_STEP_HI: begin
          if (int'(wait_cnt) >= STEP_HIGH - 1) begin
            state      <= S_STEP_LO;
            debug_step <= 1'b0;
            wait_cnt   <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_STEP_LO: begin
          if (int'(wait_cnt) >= STEP_HIGH - 1) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            step_pend <= 1'b0;
`ifdef DEBUG_AUTODUMP_EN
            dump_pend <= 1'b1;
`else
            dump_pend <= dump_pend;
`endif
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_ADDR: begin
          debug_addr <= idx_is_pc ? 7'h40 : {2'b00, idx[4:0]};
          wait_cnt   <= '0;
          state      <= S_SETTLE;
        end

        S_SETTLE: begin
          // debug_addr has been stable for SETTLE cycles when the word is taken.
          if (int'(wait_cnt) >= SETTLE - 1) begin
            word_r <= debug_data;
            ch     <= '0;
            state  <= S_SEND;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_SEND: begin
          // tx_load fires this cycle whenever the UART is ready.
          if (tx_ready) begin
            if (last_char) state <= S_NEXT;
            else           ch    <= ch + 4'd1;
          end
        end

        S_NEXT: begin
          if (idx_is_pc) begin
            dump_pend <= 1'b0;
            idx       <= '0;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end else begin
            idx   <= idx + 6'd1;
            state <= S_ADDR;
          end
        end

        default: begin
          state      <= S_IDLE;
          debug_step <= 1'b0;
          busy       <= 1'b0;
        end
      endcase

      if (step_rise) step_pend <= 1'b1;
      if (dump_req)  dump_pend <= 1'b1;
    end
  end

  debug_monitor_uart_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_uart_tx (
    .clk   (clk),
    .rst   (rst),
    .load  (tx_load),
    .data  (tx_char),
    .ready (tx_ready),
    .tx    (tx)
  );

endmodule
